// File: rtl/imm_decode_pipe.sv
// Registered RV32I/RV64I immediate decode stage with a 1-entry skid buffer.
// Optional macro IMMDEC_CSR_EN enables SYSTEM-opcode decode (CSR address and zimm).
module imm_decode_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_imm,
  output logic [WIDTH-1:0] out_target,
  output logic [WIDTH-1:0] out_pc,
  output logic [2:0]       out_fmt,
  output logic             out_illegal
);

  localparam int SHAMT_W = (WIDTH == 64) ? 6 : 5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic             illegal;
    logic [2:0]       fmt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] imm;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{illegal: 1'b0, fmt: 3'd7, pc: '0, target: '0, imm: '0};

  logic [6:0] opcode;
  logic [2:0] funct3;

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  logic [WIDTH-1:0] dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_illegal;
  entry_t           dec_entry;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign imm_i  = in_instr[31:20];
  assign imm_s  = {in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Every legal opcode ends in 2'b11, so compressed/garbage encodings fall to default.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = 3'd7;
    dec_illegal = 1'b1;
    case (opcode)
      7'b0110011: begin
        dec_fmt     = 3'd0;
        dec_illegal = 1'b0;
      end
      7'b0010011: begin
        dec_fmt     = 3'd1;
        dec_illegal = 1'b0;
        if (funct3 == 3'b001 || funct3 == 3'b101)
          dec_imm = WIDTH'(in_instr[20 +: SHAMT_W]);
        else
          dec_imm = WIDTH'(imm_i);
      end
      7'b0000011, 7'b1100111: begin
        dec_imm     = WIDTH'(imm_i);
        dec_fmt     = 3'd1;
        dec_illegal = 1'b0;
      end
      7'b0100011: begin
        dec_imm     = WIDTH'(imm_s);
        dec_fmt     = 3'd2;
        dec_illegal = 1'b0;
      end
      7'b1100011: begin
        dec_imm     = WIDTH'(imm_b);
        dec_fmt     = 3'd3;
        dec_illegal = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm     = WIDTH'(imm_u);
        dec_fmt     = 3'd4;
        dec_illegal = 1'b0;
      end
      7'b1101111: begin
        dec_imm     = WIDTH'(imm_j);
        dec_fmt     = 3'd5;
        dec_illegal = 1'b0;
      end
`ifdef IMMDEC_CSR_EN
      7'b1110011: begin
        dec_illegal = 1'b0;
        if (funct3[2]) begin
          dec_imm = WIDTH'(in_instr[19:15]);
          dec_fmt = 3'd6;
        end else begin
          dec_imm = WIDTH'(imm_i);
          dec_fmt = 3'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign dec_entry = '{illegal: dec_illegal, fmt: dec_fmt, pc: in_pc,
                       target: in_pc + dec_imm, imm: dec_imm};

  logic [1:0] state_reg;
  entry_t     out_reg;
  entry_t     skid_reg;
  logic       accept;
  logic       drain;

  // Both handshake outputs depend only on the state register, never on out_ready.
  assign in_ready  = (state_reg != ST_FULL);
  assign out_valid = (state_reg != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      out_reg   <= RESET_ENTRY;
      skid_reg  <= RESET_ENTRY;
    end else if (flush) begin
      state_reg <= ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            out_reg   <= dec_entry;
            state_reg <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_reg <= dec_entry;
          end else if (accept) begin
            skid_reg  <= dec_entry;
            state_reg <= ST_FULL;
          end else if (drain) begin
            state_reg <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            out_reg   <= skid_reg;
            state_reg <= ST_ONE;
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign out_imm     = out_reg.imm;
  assign out_target  = out_reg.target;
  assign out_pc      = out_reg.pc;
  assign out_fmt     = out_reg.fmt;
  assign out_illegal = out_reg.illegal;

endmodule
